// File: rtl/top_pkg.sv
// Shared constants and types for the 10-bit LED counter demo.
// Optional build macro COUNTER_SATURATE_EN is consumed by top.sv.
package top_pkg;

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned DEF_PRESCALE = 2_500_000;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks (PRESCALE >= 2).
module tick_gen
    import top_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (pre_q == LAST) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = (pre_q == LAST);

endmodule

// File: rtl/top.sv
// Board top: synchronized switches/keys drive a prescaled up/down counter on LEDR.
// Define COUNTER_SATURATE_EN to clamp at the ends instead of wrapping.
module top #(
    parameter int unsigned PRESCALE = top_pkg::DEF_PRESCALE,
    parameter int unsigned CNT_W    = top_pkg::CNT_W
) (
    input  logic             CLOCK_50,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [CNT_W-1:0] LEDR
);

    import top_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reset asserts asynchronously but releases on the clock.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge CLOCK_50 or posedge KEY[0]) begin
        if (KEY[0]) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    logic unused_key3;
    assign unused_key3 = KEY[3];

    // {KEY[2:1], SW[9:0]} through a two-flop synchronizer.
    logic [11:0] in_meta_q, in_sync_q;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            in_meta_q <= '0;
            in_sync_q <= '0;
        end else begin
            in_meta_q <= {KEY[2:1], SW};
            in_sync_q <= in_meta_q;
        end
    end

    logic       load_s, step_key_s, en_s;
    logic [7:0] load_val_s;
    dir_e       dir_s;

    assign step_key_s = in_sync_q[11];
    assign load_s     = in_sync_q[10];
    assign en_s       = in_sync_q[9];
    assign dir_s      = dir_e'(in_sync_q[8]);
    assign load_val_s = in_sync_q[7:0];

    logic step_prev_q;
    logic step;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= step_key_s;
        end
    end

    assign step = step_key_s & ~step_prev_q;

    logic tick;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (rst),
        .tick     (tick)
    );

    logic             advance;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Step and tick on the same cycle still move the count by one.
    assign advance = step | (tick & en_s);

    always_comb begin
        cnt_d = cnt_q;
        if (load_s) begin
            cnt_d = CNT_W'(load_val_s);
        end else if (advance) begin
            if (dir_s == DIR_UP) begin
`ifdef COUNTER_SATURATE_EN
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                cnt_d = cnt_q + 1'b1;
`endif
            end else begin
`ifdef COUNTER_SATURATE_EN
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                cnt_d = cnt_q - 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign LEDR = cnt_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for top with PRESCALE=4; expected LEDR values are derived from edge arithmetic.
module tb_top;

    logic       clk;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;

    int n_checks;
    int n_fail;
    int ecnt;
    int rel;

    top #(
        .PRESCALE (4)
    ) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .LEDR     (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    task automatic run_to(input int e);
        while (ecnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // First edge at or after x on which the prescaler tick is high.
    function automatic int next_tick(input int x);
        int y;
        y = x;
        while (((y - rel) % 4) != 2) y++;
        return y;
    endfunction

    task automatic test_reset;
        key = 4'b0001;
        sw  = 10'h3FF;
        #1;
        n_checks++;
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_immediate: LEDR=%0d required 0", ledr);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ledr !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: LEDR=%0d required 0", i, ledr);
            end
        end
        sw  = 10'h200;
        key = 4'b0000;
        rel = ecnt;
    endtask

    task automatic test_count_up;
        int pts[5];
        int exp[5];
        pts = '{5, 6, 9, 10, 42};
        exp = '{0, 1, 1, 2, 10};
        for (int i = 0; i < 5; i++) begin
            run_to(rel + pts[i]);
            n_checks++;
            if (ledr !== 10'(exp[i])) begin
                n_fail++;
                $display("FAIL count_up@%0d: LEDR=%0d required %0d", pts[i], ledr, exp[i]);
            end
        end
    endtask

    task automatic test_load_wrap;
        int e;
        int t;
        e   = ecnt;
        sw  = 10'h0FF;
        key = 4'b0010;
        run_to(e + 1);
        key = 4'b0000;
        run_to(e + 3);
        n_checks++;
        if (ledr !== 10'd255) begin
            n_fail++;
            $display("FAIL load_ff: LEDR=%0d required 255", ledr);
        end
        run_to(e + 8);
        n_checks++;
        if (ledr !== 10'd255) begin
            n_fail++;
            $display("FAIL load_ff_hold: LEDR=%0d required 255", ledr);
        end
        e   = ecnt;
        sw  = 10'h000;
        key = 4'b0010;
        run_to(e + 1);
        key = 4'b0000;
        run_to(e + 3);
        n_checks++;
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL load_zero: LEDR=%0d required 0", ledr);
        end
        e  = ecnt;
        sw = 10'h300;
        t  = next_tick(e + 3);
        run_to(t - 1);
        n_checks++;
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL down_pre_tick: LEDR=%0d required 0", ledr);
        end
        run_to(t);
        n_checks++;
`ifdef COUNTER_SATURATE_EN
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL down_sat: LEDR=%0d required 0", ledr);
        end
`else
        if (ledr !== 10'd1023) begin
            n_fail++;
            $display("FAIL down_wrap: LEDR=%0d required 1023", ledr);
        end
`endif
        run_to(t + 4);
        n_checks++;
`ifdef COUNTER_SATURATE_EN
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL down_sat2: LEDR=%0d required 0", ledr);
        end
`else
        if (ledr !== 10'd1022) begin
            n_fail++;
            $display("FAIL down_wrap2: LEDR=%0d required 1022", ledr);
        end
`endif
    endtask

    task automatic test_step;
        int e;
        int p;
        e   = ecnt;
        sw  = 10'h000;
        key = 4'b0010;
        run_to(e + 1);
        key = 4'b0000;
        run_to(e + 3);
        n_checks++;
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL step_preload: LEDR=%0d required 0", ledr);
        end
        for (int i = 1; i <= 3; i++) begin
            p   = ecnt;
            key = 4'b0100;
            run_to(p + 2);
            n_checks++;
            if (ledr !== 10'(i - 1)) begin
                n_fail++;
                $display("FAIL step%0d_before: LEDR=%0d required %0d", i, ledr, i - 1);
            end
            run_to(p + 3);
            n_checks++;
            if (ledr !== 10'(i)) begin
                n_fail++;
                $display("FAIL step%0d_edge: LEDR=%0d required %0d", i, ledr, i);
            end
            run_to(p + 10);
            n_checks++;
            if (ledr !== 10'(i)) begin
                n_fail++;
                $display("FAIL step%0d_held: LEDR=%0d required %0d", i, ledr, i);
            end
            key = 4'b0000;
            run_to(p + 20);
        end
    endtask

    task automatic test_priority;
        int e;
        int r;
        int tf;
        int t2;
        e   = ecnt;
        sw  = 10'h25A;
        key = 4'b0010;
        run_to(e + 3);
        n_checks++;
        if (ledr !== 10'h05A) begin
            n_fail++;
            $display("FAIL prio_load: LEDR=%0h required 5a", ledr);
        end
        key = 4'b0110;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ledr !== 10'h05A) begin
                n_fail++;
                $display("FAIL prio_hold[%0d]: LEDR=%0h required 5a", i, ledr);
            end
        end
        r   = ecnt;
        key = 4'b0000;
        tf  = next_tick(r + 3);
        run_to(tf - 1);
        n_checks++;
        if (ledr !== 10'h05A) begin
            n_fail++;
            $display("FAIL prio_release: LEDR=%0h required 5a", ledr);
        end
        run_to(tf);
        n_checks++;
        if (ledr !== 10'h05B) begin
            n_fail++;
            $display("FAIL prio_first_tick: LEDR=%0h required 5b", ledr);
        end
        t2 = tf + 4;
        run_to(t2 - 3);
        key = 4'b0100;
        run_to(t2 - 1);
        n_checks++;
        if (ledr !== 10'h05B) begin
            n_fail++;
            $display("FAIL coincide_before: LEDR=%0h required 5b", ledr);
        end
        run_to(t2);
        n_checks++;
        if (ledr !== 10'h05C) begin
            n_fail++;
            $display("FAIL coincide_single: LEDR=%0h required 5c", ledr);
        end
        run_to(t2 + 4);
        n_checks++;
        if (ledr !== 10'h05D) begin
            n_fail++;
            $display("FAIL coincide_next: LEDR=%0h required 5d", ledr);
        end
        key = 4'b0000;
    endtask

    task automatic test_freeze;
        int e;
        int t;
        e   = ecnt;
        sw  = 10'h004;
        key = 4'b0010;
        run_to(e + 1);
        key = 4'b0000;
        run_to(e + 3);
        n_checks++;
        if (ledr !== 10'd4) begin
            n_fail++;
            $display("FAIL freeze_load: LEDR=%0d required 4", ledr);
        end
        e  = ecnt;
        sw = 10'h204;
        t  = next_tick(e + 3);
        run_to(t);
        sw = 10'h004;
        n_checks++;
        if (ledr !== 10'd5) begin
            n_fail++;
            $display("FAIL freeze_reach5: LEDR=%0d required 5", ledr);
        end
        run_to(t + 50);
        n_checks++;
        if (ledr !== 10'd5) begin
            n_fail++;
            $display("FAIL freeze_mid: LEDR=%0d required 5", ledr);
        end
        run_to(t + 100);
        n_checks++;
        if (ledr !== 10'd5) begin
            n_fail++;
            $display("FAIL freeze_end: LEDR=%0d required 5", ledr);
        end
        e  = ecnt;
        sw = 10'h204;
        t  = next_tick(e + 3);
        run_to(t - 1);
        n_checks++;
        if (ledr !== 10'd5) begin
            n_fail++;
            $display("FAIL reenable_before: LEDR=%0d required 5", ledr);
        end
        run_to(t);
        n_checks++;
        if (ledr !== 10'd6) begin
            n_fail++;
            $display("FAIL reenable_tick: LEDR=%0d required 6", ledr);
        end
    endtask

    task automatic test_reset_mid;
        int e;
        e   = ecnt;
        sw  = 10'h2AA;
        key = 4'b0010;
        run_to(e + 4);
        n_checks++;
        if (ledr !== 10'h0AA) begin
            n_fail++;
            $display("FAIL mid_load: LEDR=%0h required aa", ledr);
        end
        @(negedge clk);
        key = 4'b0011;
        #1;
        n_checks++;
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset_immediate: LEDR=%0d required 0", ledr);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ledr !== 10'd0) begin
                n_fail++;
                $display("FAIL mid_reset_hold[%0d]: LEDR=%0d required 0", i, ledr);
            end
        end
        sw  = 10'h200;
        key = 4'b0000;
        rel = ecnt;
        run_to(rel + 5);
        n_checks++;
        if (ledr !== 10'd0) begin
            n_fail++;
            $display("FAIL resume_zero: LEDR=%0d required 0", ledr);
        end
        run_to(rel + 6);
        n_checks++;
        if (ledr !== 10'd1) begin
            n_fail++;
            $display("FAIL resume_one: LEDR=%0d required 1", ledr);
        end
        run_to(rel + 10);
        n_checks++;
        if (ledr !== 10'd2) begin
            n_fail++;
            $display("FAIL resume_two: LEDR=%0d required 2", ledr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ecnt     = 0;
        rel      = 0;
        test_reset();
        test_count_up();
        test_load_wrap();
        test_step();
        test_priority();
        test_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
Name: top

Overview:
- Board-level top of the 10-bit LED counter demo for the DE-series simulator; sits directly under the simulation harness.
- Divides CLOCK_50 into a count tick and runs a 10-bit up/down counter shown on LEDR[9:0].
- Switches give enable, direction and load value; pushbuttons give reset, load and single-step.

Parameters:
- PRESCALE, 2_500_000, CLOCK_50 cycles per count tick (20 Hz); must be ≥2.
- CNT_W, 10, counter width; equals LEDR width.

Ports:
- CLOCK_50  input  1   50 MHz clock, sole clock domain.
- KEY  input  4
  - KEY[0]: asynchronous active-high reset.
  - KEY[1]: load, active-high.
  - KEY[2]: single-step, active-high.
  - KEY[3]: unused, ignored.
- SW  input  10
  - SW[9]: count enable.
  - SW[8]: direction (0 up, 1 down).
  - SW[7:0]: load value.
- LEDR  output  10  current counter value.

Behaviour:
- Reset: KEY[0]=1 asynchronously clears counter, prescaler, synchronizers and edge detector. LEDR=0 while reset is held; release is synchronized internally through a 2-flop reset synchronizer.
- Input sync: KEY[2:1] and SW[9:0] each pass a 2-flop synchronizer. All references below are to synchronized values. Input-to-LEDR latency is 3 CLOCK_50 edges.
- Prescaler:
  - Counts 0..PRESCALE-1, wraps, free-running, cleared only by reset.
  - tick=1 for exactly one cycle when the count equals PRESCALE-1.
- Counter update, priority highest first, one action per cycle:
  1. load=1 (level): count <= {2'b00, SW[7:0]}; repeats every cycle while held; ticks and steps ignored.
  2. step: rising edge of synchronized KEY[2] (registered previous value) gives one count in the SW[8] direction, regardless of SW[9].
  3. tick & SW[9]: one count in the SW[8] direction.
- If step and tick coincide, the counter moves by exactly 1, not 2.
- Wrap: up from 1023 gives 0; down from 0 gives 1023 (modulo 2^CNT_W). Applies unless the optional feature is enabled.
- Direction change takes effect on the next tick/step; no glitch.
- SW[9]=0 freezes the count; the prescaler keeps running.
- LEDR is registered: LEDR = count, no combinational path from inputs.
- Reset asserted mid-count or mid-load: immediate clear to 0; counting resumes from 0 after release.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined: up at 1023 holds at 1023; down at 0 holds at 0. Load is unaffected.
- Undefined: modulo wrap as in Behaviour.

Decomposition:
- Package top_pkg:
  - CNT_W=10, DEF_PRESCALE=2_500_000.
  - typedef cnt_t (logic [CNT_W-1:0]).
  - enum dir_e {DIR_UP=0, DIR_DOWN=1}.
- One sub-module tick_gen: parameter PRESCALE; ports CLOCK_50, reset, tick. Holds the prescaler.
- Synchronizers, edge detect and counter live in top.

Test Plan (PRESCALE=4 overridden):
- Reset: KEY[0]=1 for 3 cycles with SW=10'h3FF -> LEDR=0 immediately and throughout; after release, counting resumes from 0.
- Count up: SW[9]=1, SW[8]=0, run 40 cycles after reset release -> LEDR increments by 1 every 4 cycles, reaching 10 (±1 for sync latency).
- Load and wrap: SW[7:0]=8'hFF, KEY[1] pulse -> LEDR=255 three cycles later. Then load 0, set SW[8]=1, enable -> next tick gives LEDR=1023; with COUNTER_SATURATE_EN LEDR stays 0.
- Step: SW[9]=0, three separate KEY[2] presses, each held 10 cycles -> LEDR goes 0→1→2→3; holding the key gives no further counts.
- Priority: KEY[1] held with SW[9]=1 and KEY[2] pressed -> LEDR stays at the SW[7:0] value throughout. Step aligned with tick -> single increment.
- Enable freeze: count to 5, set SW[9]=0 for 100 cycles -> LEDR stays 5; re-enable -> 6 within 4 cycles plus sync latency.
